// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives the PC and memory handshake to fetch
// an instruction word (and optionally one immediate word), starts the execute
// unit, and handles jumps and memory timeouts.
// Build option: define FETCH_SEQ_IMM_EN to enable the immediate-word fetch path.
module fetch_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int WAIT_MAX   = 15
) (
  input  logic                  clk,
  input  logic                  notReset,
  input  logic                  run,
  input  logic                  mem_ack,
  input  logic                  exec_done,
  input  logic                  jmp_req,
  input  logic                  has_imm,
  input  logic [DATA_WIDTH-1:0] data_bus,
  output logic                  mem_req,
  output logic                  pc_notClr,
  output logic                  pc_notWrite,
  output logic                  pc_read,
  output logic                  pc_inc,
  output logic                  ir_load,
  output logic                  imm_load,
  output logic                  exec_start,
  output logic                  busy,
  output logic                  fault,
  output logic [2:0]            state,
  output logic [DATA_WIDTH-1:0] ir_word
);

  localparam logic [2:0] S_CLR       = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_ADDR      = 3'd2;
  localparam logic [2:0] S_LATCH     = 3'd3;
  localparam logic [2:0] S_IMM_ADDR  = 3'd4;
  localparam logic [2:0] S_IMM_LATCH = 3'd5;
  localparam logic [2:0] S_EXEC      = 3'd6;
  localparam logic [2:0] S_JUMP      = 3'd7;

  // Last wait-counter value before the access is declared timed out.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  logic [2:0] state_q, state_d;
  logic       fault_q, fault_d;
  logic [7:0] wait_q, wait_d;
  logic       exec_seen_q;
  logic       addr_phase;

  assign addr_phase = (state_q == S_ADDR) || (state_q == S_IMM_ADDR);

`ifndef FETCH_SEQ_IMM_EN
  logic unused_has_imm;
  assign unused_has_imm = has_imm;
`endif

  // Next-state, fault and wait-counter logic; the counter is held at zero
  // outside address phases so every address phase starts from a clean count.
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    wait_d  = '0;
    case (state_q)
      S_CLR:  state_d = S_IDLE;
      S_IDLE: if (run && !fault_q) state_d = S_ADDR;
      S_ADDR, S_IMM_ADDR: begin
        // An ack on the final wait cycle still wins over the timeout.
        if (mem_ack) begin
          state_d = (state_q == S_ADDR) ? S_LATCH : S_IMM_LATCH;
        end else if (wait_q == WAIT_LAST) begin
          fault_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_LATCH: begin
`ifdef FETCH_SEQ_IMM_EN
        state_d = has_imm ? S_IMM_ADDR : S_EXEC;
`else
        state_d = S_EXEC;
`endif
      end
      S_IMM_LATCH: state_d = S_EXEC;
      S_EXEC: begin
        if (exec_done) begin
          if (jmp_req)  state_d = S_JUMP;
          else if (run) state_d = S_ADDR;
          else          state_d = S_IDLE;
        end
      end
      S_JUMP:  state_d = run ? S_ADDR : S_IDLE;
      default: state_d = S_CLR;
    endcase
  end

  // State registers with asynchronous active-low reset into CLR.
  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      state_q     <= S_CLR;
      fault_q     <= 1'b0;
      wait_q      <= '0;
      exec_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fault_q     <= fault_d;
      wait_q      <= wait_d;
      exec_seen_q <= (state_q == S_EXEC);
    end
  end

  // Output decode from the current state.
  always_comb begin
    mem_req     = addr_phase;
    pc_read     = addr_phase;
    pc_inc      = (state_q == S_LATCH) || (state_q == S_IMM_LATCH);
    pc_notWrite = (state_q != S_JUMP);
    // Gated by reset so the clear pulse only fires after reset is released.
    pc_notClr   = !((state_q == S_CLR) && notReset);
    ir_load     = (state_q == S_LATCH);
`ifdef FETCH_SEQ_IMM_EN
    imm_load    = (state_q == S_IMM_LATCH);
`else
    imm_load    = 1'b0;
`endif
    exec_start  = (state_q == S_EXEC) && !exec_seen_q;
    busy        = (state_q != S_IDLE) && (state_q != S_CLR);
    fault       = fault_q;
    state       = state_q;
    ir_word     = data_bus;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with hand-computed per-cycle expectations.
module tb_fetch_sequencer;

  localparam logic [2:0] S_CLR = 3'd0, S_IDLE = 3'd1, S_ADDR = 3'd2, S_LATCH = 3'd3,
                         S_IMM_ADDR = 3'd4, S_IMM_LATCH = 3'd5, S_EXEC = 3'd6, S_JUMP = 3'd7;

  // Output vector layout: {mem_req,pc_read,pc_inc}_{pc_notWrite,pc_notClr}_
  //                       {ir_load,imm_load,exec_start}_{busy,fault}
  localparam logic [9:0] V_RST      = 10'b000_11_000_00;
  localparam logic [9:0] V_CLR      = 10'b000_10_000_00;
  localparam logic [9:0] V_IDLE     = 10'b000_11_000_00;
  localparam logic [9:0] V_ADDR     = 10'b110_11_000_10;
  localparam logic [9:0] V_LATCH    = 10'b001_11_100_10;
  localparam logic [9:0] V_IMMLATCH = 10'b001_11_010_10;
  localparam logic [9:0] V_EXEC0    = 10'b000_11_001_10;
  localparam logic [9:0] V_EXEC     = 10'b000_11_000_10;
  localparam logic [9:0] V_JUMP     = 10'b000_01_000_10;
  localparam logic [9:0] V_FAULT    = 10'b000_11_000_01;

  logic        clk, notReset, run, mem_ack, exec_done, jmp_req, has_imm;
  logic [15:0] data_bus, ir_word;
  logic        mem_req, pc_notClr, pc_notWrite, pc_read, pc_inc;
  logic        ir_load, imm_load, exec_start, busy, fault;
  logic [2:0]  state;
  logic [9:0]  outs;

  int n_checks = 0;
  int n_pass   = 0;
  int n_ir = 0, n_inc = 0, n_es = 0, n_imm = 0, n_nw = 0;
  int s_ir, s_inc, s_es, s_imm, s_nw;

  fetch_sequencer #(.DATA_WIDTH(16), .WAIT_MAX(3)) dut (
    .clk(clk), .notReset(notReset), .run(run), .mem_ack(mem_ack),
    .exec_done(exec_done), .jmp_req(jmp_req), .has_imm(has_imm),
    .data_bus(data_bus), .mem_req(mem_req), .pc_notClr(pc_notClr),
    .pc_notWrite(pc_notWrite), .pc_read(pc_read), .pc_inc(pc_inc),
    .ir_load(ir_load), .imm_load(imm_load), .exec_start(exec_start),
    .busy(busy), .fault(fault), .state(state), .ir_word(ir_word)
  );

  assign outs = {mem_req, pc_read, pc_inc, pc_notWrite, pc_notClr,
                 ir_load, imm_load, exec_start, busy, fault};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe pulse counters, sampled at each active edge.
  always @(posedge clk) begin
    if (ir_load)      n_ir  <= n_ir + 1;
    if (pc_inc)       n_inc <= n_inc + 1;
    if (exec_start)   n_es  <= n_es + 1;
    if (imm_load)     n_imm <= n_imm + 1;
    if (!pc_notWrite) n_nw  <= n_nw + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic expect_cyc(input string tag, input logic [2:0] st, input logic [9:0] v);
    @(negedge clk);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".outs"}, 32'(outs), 32'(v));
  endtask

  task automatic snap();
    s_ir = n_ir; s_inc = n_inc; s_es = n_es; s_imm = n_imm; s_nw = n_nw;
  endtask

  initial begin
    notReset = 1'b0; run = 1'b0; mem_ack = 1'b0; exec_done = 1'b0;
    jmp_req = 1'b0; has_imm = 1'b0; data_bus = 16'hA5C3;
    #2;
    check("rst.state", 32'(state), 32'(S_CLR));
    check("rst.outs", 32'(outs), 32'(V_RST));
    check("ir_word", 32'(ir_word), 32'h0000A5C3);

    // Plain fetch, ack after one wait cycle, exec_done after 3 cycles, run dropped in EXEC.
    @(posedge clk); @(posedge clk); #1 notReset = 1'b1; run = 1'b1;
    expect_cyc("s1.clr", S_CLR, V_CLR);
    expect_cyc("s1.idle", S_IDLE, V_IDLE);
    snap();
    expect_cyc("s1.addr0", S_ADDR, V_ADDR);
    exec_done = 1'b1;
    expect_cyc("s1.addr1", S_ADDR, V_ADDR);
    exec_done = 1'b0; mem_ack = 1'b1;
    expect_cyc("s1.latch", S_LATCH, V_LATCH);
    mem_ack = 1'b0;
    expect_cyc("s1.exec0", S_EXEC, V_EXEC0);
    expect_cyc("s1.exec1", S_EXEC, V_EXEC);
    run = 1'b0;
    expect_cyc("s1.exec2", S_EXEC, V_EXEC);
    exec_done = 1'b1;
    expect_cyc("s1.idle_end", S_IDLE, V_IDLE);
    exec_done = 1'b0;
    check("s1.ir_cnt", 32'(n_ir - s_ir), 32'd1);
    check("s1.inc_cnt", 32'(n_inc - s_inc), 32'd1);
    check("s1.es_cnt", 32'(n_es - s_es), 32'd1);

    // Stray ack/done in IDLE ignored; then immediate-ack fetch followed by a jump.
    mem_ack = 1'b1; exec_done = 1'b1;
    expect_cyc("s2.idle_ign", S_IDLE, V_IDLE);
    exec_done = 1'b0; run = 1'b1;
`ifndef FETCH_SEQ_IMM_EN
    has_imm = 1'b1;
`endif
    expect_cyc("s2.addr", S_ADDR, V_ADDR);
    expect_cyc("s2.latch", S_LATCH, V_LATCH);
    mem_ack = 1'b0; has_imm = 1'b0;
    expect_cyc("s2.exec0", S_EXEC, V_EXEC0);
    snap();
    exec_done = 1'b1; jmp_req = 1'b1;
    expect_cyc("s2.jump", S_JUMP, V_JUMP);
    exec_done = 1'b0; jmp_req = 1'b0;
    expect_cyc("s2.addr_jmp", S_ADDR, V_ADDR);
    check("s2.nw_cnt", 32'(n_nw - s_nw), 32'd1);

    // Ack on the last permitted wait cycle, then a genuine timeout.
    expect_cyc("s3.addr1", S_ADDR, V_ADDR);
    expect_cyc("s3.addr2", S_ADDR, V_ADDR);
    mem_ack = 1'b1;
    expect_cyc("s3.late_ack", S_LATCH, V_LATCH);
    mem_ack = 1'b0;
    expect_cyc("s3.exec0", S_EXEC, V_EXEC0);
    exec_done = 1'b1;
    expect_cyc("s3.addr0b", S_ADDR, V_ADDR);
    exec_done = 1'b0;
    expect_cyc("s3.addr1b", S_ADDR, V_ADDR);
    expect_cyc("s3.addr2b", S_ADDR, V_ADDR);
    expect_cyc("s3.fault", S_IDLE, V_FAULT);
    mem_ack = 1'b1;
    expect_cyc("s3.sticky1", S_IDLE, V_FAULT);
    expect_cyc("s3.sticky2", S_IDLE, V_FAULT);
    mem_ack = 1'b0;

    // Reset clears the fault; then reset mid-handshake.
    notReset = 1'b0;
    #1;
    check("s4.clr_fault.state", 32'(state), 32'(S_CLR));
    check("s4.clr_fault.outs", 32'(outs), 32'(V_RST));
    @(posedge clk); #1 notReset = 1'b1;
    expect_cyc("s4.clr_a", S_CLR, V_CLR);
    expect_cyc("s4.idle_a", S_IDLE, V_IDLE);
    expect_cyc("s4.addr_a", S_ADDR, V_ADDR);
    #2 notReset = 1'b0;
    #1;
    check("s4.midreq.state", 32'(state), 32'(S_CLR));
    check("s4.midreq.outs", 32'(outs), 32'(V_RST));
    @(posedge clk); #1 notReset = 1'b1;
    expect_cyc("s4.clr_b", S_CLR, V_CLR);
    expect_cyc("s4.idle_b", S_IDLE, V_IDLE);
    expect_cyc("s4.addr_b", S_ADDR, V_ADDR);

    // Immediate-word handling.
    snap();
    mem_ack = 1'b1; has_imm = 1'b1;
    expect_cyc("s5.latch", S_LATCH, V_LATCH);
`ifdef FETCH_SEQ_IMM_EN
    expect_cyc("s5.imm_addr", S_IMM_ADDR, V_ADDR);
    expect_cyc("s5.imm_latch", S_IMM_LATCH, V_IMMLATCH);
    mem_ack = 1'b0; has_imm = 1'b0;
    expect_cyc("s5.exec0", S_EXEC, V_EXEC0);
    check("s5.inc_cnt", 32'(n_inc - s_inc), 32'd2);
    check("s5.imm_cnt", 32'(n_imm - s_imm), 32'd1);
`else
    mem_ack = 1'b0;
    expect_cyc("s5.exec0", S_EXEC, V_EXEC0);
    has_imm = 1'b0;
    check("s5.inc_cnt", 32'(n_inc - s_inc), 32'd1);
    check("s5.imm_cnt", 32'(n_imm - s_imm), 32'd0);
`endif
    check("s5.ir_cnt", 32'(n_ir - s_ir), 32'd1);
    exec_done = 1'b1; run = 1'b0;
    expect_cyc("s5.idle", S_IDLE, V_IDLE);
    exec_done = 1'b0;
    expect_cyc("s5.idle_hold", S_IDLE, V_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
